// File: rtl/bist_pkg.sv
// Shared definitions for the ALU BIST output-response analyzer.
package bist_pkg;

    localparam int RESP_W = 9;

    // Feedback taps for x^9 + x^5 + 1: the MSB folds back into bits 5 and 0.
    localparam logic [RESP_W-1:0] MISR_TAPS = 9'h021;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        CHECK,
        DONE
    } state_t;

    function automatic logic [RESP_W-1:0] misr_next(input logic [RESP_W-1:0] s,
                                                    input logic [RESP_W-1:0] d);
        return {s[RESP_W-2:0], 1'b0} ^ (s[RESP_W-1] ? MISR_TAPS : '0) ^ d;
    endfunction

endpackage

// File: rtl/bist_misr_analyzer_if.sv
// Controller-facing handshake and result bus of the MISR analyzer.
interface bist_misr_analyzer_if
    import bist_pkg::*;
#(
    parameter int NUM_PATTERNS = 256
);
    localparam int CW = $clog2(NUM_PATTERNS + 1);

    logic              start;
    logic              resp_valid;
    logic [RESP_W-1:0] resp_data;
    logic [RESP_W-1:0] golden_sig;
    logic              busy;
    logic              done;
    logic              pass;
    logic [RESP_W-1:0] signature;
    logic [CW-1:0]     pat_count;

    modport master (
        output start, resp_valid, resp_data, golden_sig,
        input  busy, done, pass, signature, pat_count
    );

    modport slave (
        input  start, resp_valid, resp_data, golden_sig,
        output busy, done, pass, signature, pat_count
    );

endinterface

// File: rtl/misr9.sv
// 9-bit multiple-input signature register; load wins over absorb.
module misr9
    import bist_pkg::*;
#(
    parameter logic [RESP_W-1:0] SEED = 9'h000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              en,
    input  logic [RESP_W-1:0] d,
    output logic [RESP_W-1:0] sig
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig <= SEED;
        end else if (load) begin
            sig <= SEED;
        end else if (en) begin
            sig <= misr_next(sig, d);
        end
    end

endmodule

// File: rtl/bist_misr_analyzer.sv
// Compacts NUM_PATTERNS ALU responses into a signature and reports a
// pass/fail verdict against the golden signature via start/busy/done.
module bist_misr_analyzer
    import bist_pkg::*;
#(
    parameter int                NUM_PATTERNS = 256,
    parameter logic [RESP_W-1:0] SEED         = 9'h000
) (
    input  logic                 clk,
    input  logic                 reset,
    bist_misr_analyzer_if.slave  io
);

    localparam int            CW   = $clog2(NUM_PATTERNS + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

    state_t            state, state_n;
    logic              load, absorb;
    logic [CW-1:0]     pat_count;
    logic [RESP_W-1:0] signature;
    logic              pass;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // start is only honoured when no run is in flight.
    always_comb begin
        state_n = state;
        load    = 1'b0;
        absorb  = 1'b0;
        case (state)
            IDLE: begin
                if (io.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (io.resp_valid) begin
                    absorb = 1'b1;
                    if (pat_count == LAST) begin
                        state_n = CHECK;
                    end
                end
            end
            CHECK: state_n = DONE;
            DONE: begin
                if (io.start) begin
                    load    = 1'b1;
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pat_count <= '0;
        end else if (load) begin
            pat_count <= '0;
        end else if (absorb) begin
            pat_count <= pat_count + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass <= 1'b0;
        end else if (load) begin
            pass <= 1'b0;
        end else if (state == CHECK) begin
            pass <= (signature == io.golden_sig);
        end
    end

    misr9 #(
        .SEED (SEED)
    ) u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .en    (absorb),
        .d     (io.resp_data),
        .sig   (signature)
    );

    assign io.busy      = (state == RUN) || (state == CHECK);
    assign io.done      = (state == DONE);
    assign io.pass      = pass;
    assign io.signature = signature;
    assign io.pat_count = pat_count;

endmodule

// File: doc/bist_misr_analyzer.md
Name: bist_misr_analyzer

Overview:
Output-response analyzer for the ALU BIST loop. It replaces per-cycle golden-ROM comparison with signature compaction. Each cycle it absorbs the 9-bit response {ALU_Out, CarryOut} into a multiple-input signature register (MISR) and counts patterns. After NUM_PATTERNS responses it compares the final signature against a golden signature and reports pass/fail through a start/busy/done handshake to the BIST controller.

Parameters:
NUM_PATTERNS, 256, number of responses compacted per run (>=1)
SEED, 9'h000, MISR value loaded on each run start
CW, $clog2(NUM_PATTERNS+1), width of pattern counter (derived localparam, not overridable)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a run; honoured in IDLE and DONE only
resp_valid  input  1  resp_data is a valid ALU response this cycle
resp_data  input  9  {ALU_Out[7:0], CarryOut}
golden_sig  input  9  expected final signature; sampled in CHECK
busy  output  1  high in RUN and CHECK
done  output  1  high in DONE; held until next start or reset
pass  output  1  registered compare result; meaningful only while done=1
signature  output  9  current MISR contents
pat_count  output  CW  responses absorbed in current/last run

Behaviour:
- Reset (async, any state, including mid-run): state=IDLE, signature=SEED, pat_count=0, busy=0, done=0, pass=0.
- MISR polynomial is x^9+x^5+1, with s = signature and d = resp_data:
  - n[0]=s[8]^d[0]
  - n[5]=s[4]^s[8]^d[5]
  - n[i]=s[i-1]^d[i] for all other i
- States:
  - IDLE: outputs idle. On start: signature<=SEED, pat_count<=0, go RUN.
  - RUN: on resp_valid: signature<=n, pat_count<=pat_count+1. If this is the NUM_PATTERNS-th accepted response, go CHECK next cycle. If resp_valid=0, hold all values (stall, no timeout). start is ignored.
  - CHECK: one cycle. pass<=(signature==golden_sig), go DONE. resp_valid is ignored.
  - DONE: done=1, busy=0; signature, pat_count and pass are frozen. On start: reload SEED, clear pat_count and pass, go RUN (back-to-back runs need no IDLE visit).
- Latency: done rises 2 cycles after the clock edge that accepts the last response (edge 1 enters CHECK, edge 2 enters DONE).
- start and resp_valid in the same IDLE cycle: the response is NOT absorbed; absorption starts the cycle after RUN is entered.
- pat_count never exceeds NUM_PATTERNS, and there is no wrap-around within a run.
- NUM_PATTERNS=1: a single accepted response moves RUN to CHECK.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Decomposition:
- Shared package bist_pkg: RESP_W=9, MISR_TAPS mask 9'h021 (x^5 and x^0 feedback positions), state enum {IDLE, RUN, CHECK, DONE}.
- One natural sub-module, misr9: a pure next-state MISR slice (s, d, en -> registered signature, with async reset to SEED and synchronous load). The FSM and counter stay in the top module.

Test Plan:
1. NUM_PATTERNS=2, SEED=0. Apply start, then resp 9'h100, then 9'h000 -> signature 9'h100, then 9'h021. With golden_sig=9'h021: done=1 two cycles after the last accept, pass=1, pat_count=2.
2. Same stimulus with golden_sig=9'h020 -> done=1, pass=0, signature=9'h021.
3. NUM_PATTERNS=4, with resp_valid low on alternate cycles -> signature and pat_count hold on stall cycles; the CHECK entry is delayed accordingly; the final signature equals the no-stall run.
4. Assert reset mid-RUN after 2 of 4 responses -> outputs return to reset values immediately (asynchronously). A fresh start then completes a full run with the correct signature.
5. Assert start while in RUN -> ignored, and pat_count continues. Assert start in DONE -> done drops the next cycle, pass clears, signature reloads to SEED.
6. Full loop with the LFSR pattern generators and the ALU, NUM_PATTERNS=256 -> signature matches the golden value computed by the reference-model bench; injecting a stuck-at-0 on CarryOut -> pass=0.
